adel_imem_loader: RTL

Instruction memory and serial program loader for the adel core. Holds a 256 x 16 instruction store, serves `inst = mem[pc]` combinationally to the core's fetch port, and accepts program images over a 3-wire SPI-style write-only link. The core's reset is held low while a load is in progress and until at least one word has been loaded.

---
 rtl/adel_pkg.sv | 17 +
 rtl/adel_imem_loader_if.sv | 27 ++
 rtl/adel_sync2.sv | 27 ++
 rtl/adel_imem_loader.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/adel_pkg.sv
// Shared constants and types for the adel instruction memory loader.
// Imported by the loader interface and RTL.
package adel_pkg;

  localparam int AW       = 8;
  localparam int IW       = 16;
  localparam int DEPTH    = 256;
  localparam int HDR_LEN  = 8;
  localparam int WORD_LEN = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } ld_state_t;

endpackage

// File: rtl/adel_imem_loader_if.sv
// Serial load link and fetch port bundle of the instruction memory.
// The host/core side uses master, the loader uses slave.
interface adel_imem_loader_if #(
  parameter int AW = adel_pkg::AW,
  parameter int IW = adel_pkg::IW
);

  logic          sck;
  logic          cs_n;
  logic          mosi;
  logic [AW-1:0] pc;
  logic [IW-1:0] inst;
  logic          core_nrst;
  logic          loaded;
  logic          wr_pulse;

  modport master (
    output sck, cs_n, mosi, pc,
    input  inst, core_nrst, loaded, wr_pulse
  );

  modport slave (
    input  sck, cs_n, mosi, pc,
    output inst, core_nrst, loaded, wr_pulse
  );

endinterface

// File: rtl/adel_sync2.sv
// Single-bit two-flop synchroniser with a selectable reset level.
// Used for the asynchronous serial link pins.
module adel_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic nrst,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/adel_imem_loader.sv
// 256x16 flop instruction store with async fetch read and a
// write-only serial loader that holds the core in reset while loading.
module adel_imem_loader
  import adel_pkg::*;
#(
  parameter int DEPTH = adel_pkg::DEPTH,
  parameter int AW    = adel_pkg::AW,
  parameter int IW    = adel_pkg::IW
) (
  input logic              clk,
  input logic              nrst,
  adel_imem_loader_if.slave bus
);

  logic sck_s;
  logic cs_s;
  logic mosi_s;
  logic sck_q;
  logic sck_rise;

  ld_state_t state_q, state_d;

  logic [3:0]    cnt_q, cnt_d;
  logic [IW-2:0] sh_q, sh_d;
  logic [IW-1:0] shin;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [IW-1:0] wdata_q, wdata_d;
  logic          wr_q, wr_d;
  logic          loaded_q;
  logic          core_nrst_q;

  logic [IW-1:0] mem_q [DEPTH];

  adel_sync2 #(.RST_VAL(1'b0)) u_sync_sck (
    .clk  (clk),
    .nrst (nrst),
    .d_i  (bus.sck),
    .q_o  (sck_s)
  );

  adel_sync2 #(.RST_VAL(1'b1)) u_sync_cs (
    .clk  (clk),
    .nrst (nrst),
    .d_i  (bus.cs_n),
    .q_o  (cs_s)
  );

  adel_sync2 #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk  (clk),
    .nrst (nrst),
    .d_i  (bus.mosi),
    .q_o  (mosi_s)
  );

  assign sck_rise = sck_s & ~sck_q;
  assign shin     = {sh_q, mosi_s};

  // Deselect is checked first so it beats a coincident 16th bit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    addr_d  = addr_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    wr_d    = 1'b0;
    if (cs_s) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = HDR;
          cnt_d   = '0;
        end
        HDR: begin
          if (sck_rise) begin
            sh_d  = shin[IW-2:0];
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'(HDR_LEN - 1)) begin
              addr_d  = shin[AW-1:0];
              cnt_d   = '0;
              state_d = DATA;
            end
          end
        end
        DATA: begin
          if (sck_rise) begin
            sh_d  = shin[IW-2:0];
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'(WORD_LEN - 1)) begin
              wr_d    = 1'b1;
              wdata_d = shin;
              waddr_d = addr_q;
              addr_d  = addr_q + AW'(1);
              cnt_d   = '0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      sck_q       <= 1'b0;
      cnt_q       <= '0;
      sh_q        <= '0;
      addr_q      <= '0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      wr_q        <= 1'b0;
      loaded_q    <= 1'b0;
      core_nrst_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sck_q       <= sck_s;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      addr_q      <= addr_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      wr_q        <= wr_d;
      loaded_q    <= loaded_q | wr_q;
      core_nrst_q <= loaded_q & cs_s;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_q) begin
      mem_q[waddr_q] <= wdata_q;
    end
  end

  assign bus.inst      = cs_s ? mem_q[bus.pc] : '0;
  assign bus.core_nrst = core_nrst_q;
  assign bus.loaded    = loaded_q;
  assign bus.wr_pulse  = wr_q;

endmodule
